// File: rtl/oric_sd_pkg.sv
// Shared definitions for the sector-protocol disk controllers.
// State encoding and sector geometry.
package oric_sd_pkg;

    localparam int SECTOR_BYTES = 512;
    localparam int SECTOR_AW    = 9;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        XFER,
        FIN
    } sd_state_e;

endpackage

// File: rtl/sector_dpram.sv
// 512x8 true dual-port sector RAM with registered read ports.
// Port B wins a same-cycle same-address write.
module sector_dpram
    import oric_sd_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [SECTOR_AW-1:0] a_addr,
    input  logic [7:0]           a_din,
    input  logic                 a_we,
    output logic [7:0]           a_dout,
    input  logic [SECTOR_AW-1:0] b_addr,
    input  logic [7:0]           b_din,
    input  logic                 b_we,
    output logic [7:0]           b_dout
);

    logic [7:0] mem [SECTOR_BYTES];

    // array writes; B is last so it keeps the byte on a collision
    always_ff @(posedge clk) begin
        if (a_we) begin
            mem[a_addr] <= a_din;
        end
        if (b_we) begin
            mem[b_addr] <= b_din;
        end
    end

    // port A registered read (read-first)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_dout <= 8'h00;
        end else begin
            a_dout <= mem[a_addr];
        end
    end

    // port B registered read (read-first)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            b_dout <= 8'h00;
        end else begin
            b_dout <= mem[b_addr];
        end
    end

endmodule

// File: rtl/sector_buffer_initiator.sv
// Initiator side of the sd_lba/sd_rd/sd_wr sector protocol.
// One sector buffer, filled from or streamed to the responder.
module sector_buffer_initiator
    import oric_sd_pkg::*;
#(
    parameter int TIMEOUT_W = 20,
    parameter int LBA_W     = 32
) (
    input  logic                 clk_i,
    input  logic                 res_n_i,
    input  logic                 cmd_rd,
    input  logic                 cmd_wr,
    input  logic [LBA_W-1:0]     cmd_lba,
    output logic                 busy,
    output logic                 done,
    output logic                 err,
    input  logic [SECTOR_AW-1:0] buf_addr,
    input  logic [7:0]           buf_din,
    input  logic                 buf_we,
    output logic [7:0]           buf_dout,
    output logic [LBA_W-1:0]     sd_lba,
    output logic                 sd_rd,
    output logic                 sd_wr,
    input  logic                 sd_ack,
    input  logic [SECTOR_AW-1:0] sd_buff_addr,
    input  logic [7:0]           sd_dout,
    input  logic                 sd_buff_wr,
    output logic [7:0]           sd_din
);

    // the request drops on the edge where the count reaches all-ones,
    // so the request is visible for 2^TIMEOUT_W-1 cycles
    localparam logic [TIMEOUT_W-1:0] TO_LAST =
        {{(TIMEOUT_W-1){1'b1}}, 1'b0};

    sd_state_e            state;
    logic [TIMEOUT_W-1:0] to_cnt;
    logic                 dir_wr;
    logic                 ack_q;
    logic                 ack_fall;
    logic                 b_we;
    logic                 a_we;
    logic                 same_addr;

    assign ack_fall  = ack_q & ~sd_ack;
    assign same_addr = (buf_addr == sd_buff_addr);

    // responder bytes land whenever an ack is live, even a residual
    // one after reset, unless a write transfer owns port B
    assign b_we = sd_buff_wr & sd_ack & ~dir_wr;

    // the responder byte is kept on a same-address collision
    assign a_we = buf_we & ~(b_we & same_addr);

    // ack history for falling-edge detection
    always_ff @(posedge clk_i or negedge res_n_i) begin
        if (!res_n_i) begin
            ack_q <= 1'b0;
        end else begin
            ack_q <= sd_ack;
        end
    end

    // command sequencer with registered handshake and status outputs
    always_ff @(posedge clk_i or negedge res_n_i) begin
        if (!res_n_i) begin
            state  <= IDLE;
            to_cnt <= '0;
            dir_wr <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
            err    <= 1'b0;
            sd_rd  <= 1'b0;
            sd_wr  <= 1'b0;
            sd_lba <= '0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (cmd_rd || cmd_wr) begin
                        sd_lba <= cmd_lba;
                        dir_wr <= ~cmd_rd;
                        sd_rd  <= cmd_rd;
                        sd_wr  <= ~cmd_rd;
                        err    <= 1'b0;
                        busy   <= 1'b1;
                        to_cnt <= '0;
                        state  <= REQ;
                    end
                end
                REQ: begin
                    to_cnt <= to_cnt + 1'b1;
                    if (sd_ack) begin
                        sd_rd  <= 1'b0;
                        sd_wr  <= 1'b0;
                        to_cnt <= '0;
                        state  <= XFER;
                    end else if (to_cnt == TO_LAST) begin
                        sd_rd <= 1'b0;
                        sd_wr <= 1'b0;
                        err   <= 1'b1;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= FIN;
                    end
                end
                XFER: begin
                    if (ack_fall) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= FIN;
                    end
                end
                FIN: begin
                    to_cnt <= '0;
                    state  <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    sector_dpram u_ram (
        .clk    (clk_i),
        .rst_n  (res_n_i),
        .a_addr (buf_addr),
        .a_din  (buf_din),
        .a_we   (a_we),
        .a_dout (buf_dout),
        .b_addr (sd_buff_addr),
        .b_din  (sd_dout),
        .b_we   (b_we),
        .b_dout (sd_din)
    );

endmodule

// File: tb/tb_sector_buffer_initiator.sv
// Directed bench for sector_buffer_initiator.
// Byte expectations flow through a scoreboard queue.
module tb_sector_buffer_initiator;

    logic        clk_i = 1'b0;
    logic        res_n_i;
    logic        cmd_rd;
    logic        cmd_wr;
    logic [31:0] cmd_lba;
    logic        busy;
    logic        done;
    logic        err;
    logic [8:0]  buf_addr;
    logic [7:0]  buf_din;
    logic        buf_we;
    logic [7:0]  buf_dout;
    logic [31:0] sd_lba;
    logic        sd_rd;
    logic        sd_wr;
    logic        sd_ack;
    logic [8:0]  sd_buff_addr;
    logic [7:0]  sd_dout;
    logic        sd_buff_wr;
    logic [7:0]  sd_din;

    int errors = 0;
    int checks = 0;
    int rd_cnt = 0;
    int wr_cnt = 0;
    int done_cnt = 0;

    logic [7:0] sb [$];
    logic [7:0] model [512];

    always #5 clk_i = ~clk_i;

    sector_buffer_initiator #(
        .TIMEOUT_W (4),
        .LBA_W     (32)
    ) dut (
        .clk_i        (clk_i),
        .res_n_i      (res_n_i),
        .cmd_rd       (cmd_rd),
        .cmd_wr       (cmd_wr),
        .cmd_lba      (cmd_lba),
        .busy         (busy),
        .done         (done),
        .err          (err),
        .buf_addr     (buf_addr),
        .buf_din      (buf_din),
        .buf_we       (buf_we),
        .buf_dout     (buf_dout),
        .sd_lba       (sd_lba),
        .sd_rd        (sd_rd),
        .sd_wr        (sd_wr),
        .sd_ack       (sd_ack),
        .sd_buff_addr (sd_buff_addr),
        .sd_dout      (sd_dout),
        .sd_buff_wr   (sd_buff_wr),
        .sd_din       (sd_din)
    );

    task automatic tick();
        @(posedge clk_i);
        #1;
        if (sd_rd) rd_cnt++;
        if (sd_wr) wr_cnt++;
        if (done) done_cnt++;
    endtask

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic sb_check(input string tag, input logic [7:0] got);
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL %s: observed=%0h expected=<none queued>",
                   tag, got);
        end else begin
            check(tag, {24'h0, got}, {24'h0, sb.pop_front()});
        end
    endtask

    task automatic wait_done(input int limit);
        for (int n = 0; n < limit && !done; n++) tick();
        check("done_seen", {31'h0, done}, 32'h1);
    endtask

    task automatic stream(input int first, input int count,
                          input logic [7:0] xr);
        for (int i = first; i < first + count; i++) begin
            sd_buff_addr = i[8:0];
            sd_dout      = i[7:0] ^ xr;
            sd_buff_wr   = 1'b1;
            model[i]     = i[7:0] ^ xr;
            tick();
        end
        sd_buff_wr = 1'b0;
    endtask

    task automatic readback(input int first, input int count,
                            input int step, input string tag);
        for (int i = first; i < first + count; i += step) begin
            sb.push_back(model[i]);
            buf_addr = i[8:0];
            tick();
            sb_check(tag, buf_dout);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        res_n_i      = 1'b0;
        cmd_rd       = 1'b0;
        cmd_wr       = 1'b0;
        cmd_lba      = 32'h0;
        buf_addr     = 9'h0;
        buf_din      = 8'h0;
        buf_we       = 1'b0;
        sd_ack       = 1'b0;
        sd_buff_addr = 9'h0;
        sd_dout      = 8'h0;
        sd_buff_wr   = 1'b0;
        repeat (3) @(posedge clk_i);
        #1;
        check("rst_busy", {31'h0, busy}, 32'h0);
        check("rst_done", {31'h0, done}, 32'h0);
        check("rst_err", {31'h0, err}, 32'h0);
        check("rst_sd_rd", {31'h0, sd_rd}, 32'h0);
        check("rst_sd_wr", {31'h0, sd_wr}, 32'h0);
        check("rst_sd_lba", sd_lba, 32'h0);
        check("rst_sd_din", {24'h0, sd_din}, 32'h0);
        check("rst_buf_dout", {24'h0, buf_dout}, 32'h0);
        res_n_i = 1'b1;
        tick();

        // read with a same-address client collision at 0x40
        rd_cnt = 0;
        done_cnt = 0;
        cmd_lba = 32'h12;
        cmd_rd = 1'b1;
        tick();
        cmd_rd = 1'b0;
        check("rd_busy", {31'h0, busy}, 32'h1);
        check("rd_lba", sd_lba, 32'h12);
        for (int n = 0; n < 8 && !sd_rd; n++) tick();
        tick();
        tick();
        sd_ack = 1'b1;
        tick();
        check("rd_req_len", rd_cnt, 3);
        check("rd_req_drop", {31'h0, sd_rd}, 32'h0);
        for (int i = 0; i < 512; i++) begin
            sd_buff_addr = i[8:0];
            sd_buff_wr   = 1'b1;
            if (i == 'h40) begin
                sd_dout  = 8'h11;
                buf_addr = 9'h040;
                buf_din  = 8'h22;
                buf_we   = 1'b1;
                model[i] = 8'h11;
            end else begin
                sd_dout  = i[7:0] ^ 8'h5A;
                buf_we   = 1'b0;
                model[i] = i[7:0] ^ 8'h5A;
            end
            tick();
        end
        sd_buff_wr = 1'b0;
        buf_we = 1'b0;
        sd_ack = 1'b0;
        wait_done(8);
        check("rd_busy_at_done", {31'h0, busy}, 32'h0);
        tick();
        tick();
        check("rd_done_once", done_cnt, 1);
        check("rd_busy_low", {31'h0, busy}, 32'h0);
        buf_addr = 9'h1FF;
        tick();
        check("rd_1ff", {24'h0, buf_dout}, 32'hA5);
        buf_addr = 9'h040;
        tick();
        check("rd_collide_40", {24'h0, buf_dout}, 32'h11);
        readback(0, 512, 1, "rd_buf");

        // write: client fills ~addr, responder reads sd_din back
        for (int i = 0; i < 512; i++) begin
            buf_addr = i[8:0];
            buf_din  = ~i[7:0];
            buf_we   = 1'b1;
            model[i] = ~i[7:0];
            tick();
        end
        buf_we = 1'b0;
        wr_cnt = 0;
        rd_cnt = 0;
        done_cnt = 0;
        cmd_lba = 32'h7;
        cmd_wr = 1'b1;
        tick();
        cmd_wr = 1'b0;
        cmd_lba = 32'hFFFF_FFFF;
        check("wr_req", {31'h0, sd_wr}, 32'h1);
        check("wr_no_rd", {31'h0, sd_rd}, 32'h0);
        check("wr_lba0", sd_lba, 32'h7);
        tick();
        check("wr_lba1", sd_lba, 32'h7);
        sd_ack = 1'b1;
        tick();
        check("wr_req_drop", {31'h0, sd_wr}, 32'h0);
        check("wr_lba2", sd_lba, 32'h7);
        for (int i = 0; i < 512; i++) begin
            if (i == 100) begin
                buf_addr   = 9'd200;
                buf_din    = 8'h3C;
                buf_we     = 1'b1;
                model[200] = 8'h3C;
            end else begin
                buf_we = 1'b0;
            end
            sd_buff_addr = i[8:0];
            sb.push_back(model[i]);
            tick();
            sb_check("wr_sd_din", sd_din);
        end
        buf_we = 1'b0;
        sd_ack = 1'b0;
        wait_done(8);
        tick();
        check("wr_done_once", done_cnt, 1);
        check("wr_rd_never", rd_cnt, 0);

        // timeout with no acknowledge
        rd_cnt = 0;
        done_cnt = 0;
        cmd_lba = 32'h5;
        cmd_rd = 1'b1;
        tick();
        cmd_rd = 1'b0;
        wait_done(40);
        check("to_req_len", rd_cnt, 15);
        check("to_err", {31'h0, err}, 32'h1);
        check("to_busy", {31'h0, busy}, 32'h0);
        check("to_rd_drop", {31'h0, sd_rd}, 32'h0);
        tick();
        tick();
        check("to_done_once", done_cnt, 1);
        check("to_err_sticky", {31'h0, err}, 32'h1);

        // simultaneous rd+wr, then a command while busy
        rd_cnt = 0;
        wr_cnt = 0;
        done_cnt = 0;
        cmd_lba = 32'h9;
        cmd_rd = 1'b1;
        cmd_wr = 1'b1;
        tick();
        cmd_rd = 1'b0;
        cmd_wr = 1'b0;
        check("col_err_clr", {31'h0, err}, 32'h0);
        check("col_rd", {31'h0, sd_rd}, 32'h1);
        check("col_no_wr", {31'h0, sd_wr}, 32'h0);
        cmd_rd = 1'b1;
        cmd_lba = 32'h99;
        tick();
        cmd_rd = 1'b0;
        check("col_lba_hold", sd_lba, 32'h9);
        sd_ack = 1'b1;
        tick();
        tick();
        sd_ack = 1'b0;
        wait_done(8);
        repeat (4) tick();
        check("col_done_once", done_cnt, 1);
        check("col_wr_never", wr_cnt, 0);
        check("col_idle", {31'h0, busy}, 32'h0);

        // reset in the middle of a read transfer
        done_cnt = 0;
        cmd_lba = 32'h33;
        cmd_rd = 1'b1;
        tick();
        cmd_rd = 1'b0;
        sd_ack = 1'b1;
        tick();
        tick();
        stream(0, 100, 8'hC3);
        res_n_i = 1'b0;
        #2;
        check("mid_rst_rd", {31'h0, sd_rd}, 32'h0);
        check("mid_rst_wr", {31'h0, sd_wr}, 32'h0);
        check("mid_rst_busy", {31'h0, busy}, 32'h0);
        check("mid_rst_done", {31'h0, done}, 32'h0);
        check("mid_rst_err", {31'h0, err}, 32'h0);
        tick();
        tick();
        res_n_i = 1'b1;
        tick();
        stream(100, 10, 8'hC3);
        sd_ack = 1'b0;
        repeat (4) tick();
        check("residual_no_done", done_cnt, 0);
        check("residual_idle", {31'h0, busy}, 32'h0);
        readback(95, 15, 1, "residual_buf");

        // a fresh read after reset completes normally
        done_cnt = 0;
        rd_cnt = 0;
        cmd_lba = 32'h44;
        cmd_rd = 1'b1;
        tick();
        cmd_rd = 1'b0;
        check("post_rst_busy", {31'h0, busy}, 32'h1);
        check("post_rst_rd", {31'h0, sd_rd}, 32'h1);
        check("post_rst_lba", sd_lba, 32'h44);
        tick();
        sd_ack = 1'b1;
        tick();
        stream(0, 512, 8'h96);
        sd_ack = 1'b0;
        wait_done(8);
        tick();
        check("post_rst_done_once", done_cnt, 1);
        check("post_rst_err", {31'h0, err}, 32'h0);
        readback(0, 512, 37, "post_rst_buf");

        check("sb_drained", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sector_buffer_initiator.md
Name: sector_buffer_initiator

Overview:
- Initiator side of the block-device sector protocol (sd_lba / sd_rd / sd_wr / sd_ack / sd_buff_*), the counterpart of the SRAM-backed image responder.
- Holds one 512-byte sector buffer.
- On a client command, requests a sector from the responder and fills the buffer (read), or streams the buffer out to the responder (write).
- The FDC/disk logic accesses the buffer through a byte port; command status is reported via busy/done/err.

Parameters:
- TIMEOUT_W, 20: width of the ack-wait timeout counter; timeout fires at 2^TIMEOUT_W-1 cycles without sd_ack.
- LBA_W, 32: width of the sector address.

Ports:
- clk_i  in  1  system clock (clk_sys domain)
- res_n_i  in  1  reset, asynchronous, active-low
- cmd_rd  in  1  one-cycle pulse: load sector cmd_lba into the buffer
- cmd_wr  in  1  one-cycle pulse: write the buffer to sector cmd_lba
- cmd_lba  in  LBA_W  sector number, sampled on the cmd pulse
- busy  out  1  command in progress
- done  out  1  one-cycle pulse when a command completes
- err  out  1  sticky timeout flag; cleared by the next accepted command
- buf_addr  in  9  client byte address
- buf_din  in  8  client write data
- buf_we  in  1  client byte write
- buf_dout  out  8  client read data, registered, 1-cycle latency
- sd_lba  out  LBA_W  requested sector
- sd_rd  out  1  read request
- sd_wr  out  1  write request
- sd_ack  in  1  responder acknowledge, high for the whole transfer
- sd_buff_addr  in  9  responder byte index
- sd_dout  in  8  byte from responder (read)
- sd_buff_wr  in  1  strobe: sd_dout is valid at sd_buff_addr
- sd_din  out  8  byte to responder (write); equals buffer[sd_buff_addr] one cycle after sd_buff_addr changes

Behaviour:
- Reset values:
  - busy=0, done=0, err=0, sd_rd=0, sd_wr=0, sd_lba=0, sd_din=0, buf_dout=0.
  - State=IDLE, timeout counter=0.
  - Buffer contents are undefined after reset.
- State machine IDLE -> REQ -> XFER -> FIN -> IDLE.
- IDLE:
  - cmd_rd or cmd_wr latches cmd_lba into sd_lba and the direction into a register.
  - Then clears err, sets busy=1, goes to REQ.
  - If cmd_rd and cmd_wr arrive in the same cycle, read wins.
  - Commands arriving while busy are ignored (no queue).
- REQ:
  - sd_rd or sd_wr is asserted from the first REQ cycle; sd_lba is held stable.
  - The timeout counter increments each cycle.
  - On sd_ack=1: deassert the request in the next cycle, clear the counter, go to XFER.
  - On counter all-ones: deassert the request, set err=1, go to FIN.
- XFER (read):
  - Each cycle with sd_buff_wr=1 writes sd_dout to buffer[sd_buff_addr].
  - Strobes with any sd_buff_addr are accepted; the address wraps naturally in 9 bits.
- XFER (write):
  - sd_din is the registered read of buffer[sd_buff_addr] on port B.
- XFER exit: on sd_ack falling (1->0), go to FIN. Byte count is not checked; the responder owns completeness.
- FIN: done=1 for exactly one cycle, busy=0 in the same cycle, return to IDLE. A new command is accepted on the cycle after FIN.
- Buffer:
  - True dual-port, 512x8, inferred RAM.
  - Port A serves the client: buf_we writes buf_din; buf_dout is the registered read of buf_addr.
  - Port B serves the responder.
- Client access is permitted while busy. The simultaneous same-address write rule is:
  - During a read transfer, a responder write and a client write to the same address in the same cycle: the responder byte is kept.
  - During a write transfer, a client write to a byte not yet streamed goes out with the new value.
- Reset mid-transfer: res_n_i low drops sd_rd/sd_wr immediately (asynchronously) and returns to IDLE. Later sd_buff_wr strobes are still written if a residual sd_ack arrives after reset release, but no done pulse is generated for them.
- If sd_ack is already high on REQ entry (stale ack), it is treated as the acknowledge.

Decomposition:
- Shared package oric_sd_pkg:
  - State enum {IDLE, REQ, XFER, FIN}.
  - Constant SECTOR_BYTES=512.
  - Constant SECTOR_AW=9.
- One sub-module: sector_dpram (512x8 true dual-port, registered outputs), reusable by other disk controllers.

Test Plan:
- Read:
  - Stimulus: cmd_rd with lba=0x12; the responder model acks 2 cycles after sd_rd, then streams 512 strobes of byte=addr^0x5A and drops ack.
  - Required: sd_rd high for 3 cycles; one done pulse; busy low; buf_dout at addr 0x1FF reads 0xA5 one cycle after buf_addr is applied.
- Write:
  - Stimulus: client fills the buffer with byte=~addr, then cmd_wr lba=7; the responder samples sd_din one cycle after each sd_buff_addr step.
  - Required: the responder captures 512 bytes equal to ~addr; sd_lba=7 throughout REQ.
- Timeout:
  - Stimulus: TIMEOUT_W=4, cmd_rd, no sd_ack.
  - Required: sd_rd drops after 15 cycles; err=1; done pulses once. A following cmd_rd clears err on acceptance.
- Collisions:
  - Stimulus: cmd_rd and cmd_wr in the same cycle.
  - Required: sd_rd asserted, sd_wr stays 0.
  - Stimulus: a second cmd_rd while busy.
  - Required: ignored; exactly one done pulse.
- Reset mid-XFER:
  - Stimulus: pull res_n_i low after 100 read strobes.
  - Required: sd_rd=sd_wr=0, busy=0, done=0, err=0 while in reset; the state returns to IDLE and a new cmd_rd completes normally.
- Same-address collision:
  - Stimulus: during a read transfer, sd_buff_wr to addr 0x40 with 0x11 and buf_we to 0x40 with 0x22 in the same cycle.
  - Required: buffer[0x40] reads 0x11.
